// File: rtl/mips_pkg.sv
// mips_pkg: shared size codes and LSU state encoding for the MIPS pipeline
package mips_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic {LSU_IDLE = 1'b0, LSU_REQ = 1'b1} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane replication and load lane extraction/extension
module lsu_align
    import mips_pkg::*;
(
    input  logic [1:0]  a,
    input  logic [1:0]  size,
    input  logic        lsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ldata
);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        sh = rdata >> {a, 3'b000};
        b = sh[7:0];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        // reserved size 11 falls through to the word case everywhere
        be = size == SZ_BYTE ? 4'b0001 << a : size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_rep = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
        ldata = size == SZ_BYTE ? {{24{lsigned & b[7]}}, b} :
                size == SZ_HALF ? {{16{lsigned & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with valid/ready data port and stall
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them.
module mem_lsu
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_memread,
    input  logic        in_memwrite,
    input  logic [1:0]  in_size,
    input  logic        in_lsigned,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_regwrite,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        lsu_stall,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        bus_err
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    lsu_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0] addr_q, wdata_q, ldata, wdata_rep;
    logic [1:0]  size_q;
    logic        sgn_q, we_q, rw_q, mem_op, mis, idle, accept, done, tmo;
    logic [4:0]  rd_q;
    logic [3:0]  be;
    lsu_align u_align (
        .a(addr_q[1:0]), .size(size_q), .lsigned(sgn_q), .wdata(wdata_q),
        .rdata(dm_rdata), .be(be), .wdata_rep(wdata_rep), .ldata(ldata)
    );
    assign mem_op = in_valid & (in_memread | in_memwrite);
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = mem_op & (in_size == SZ_HALF ? in_addr[0] : in_size[1] & |in_addr[1:0]);
`else
    assign mis = 1'b0;
`endif
    assign idle   = state == LSU_IDLE;
    assign accept = idle & mem_op & ~mis;
    assign done   = ~idle & dm_ready;
    // dm_ready in the final wait cycle still counts as a completion
    assign tmo    = ~idle & ~dm_ready & (cnt == CW'(WAIT_MAX));
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= LSU_IDLE;
        else state <= state_nx;
    always_comb state_nx = idle ? (accept ? LSU_REQ : LSU_IDLE) : (done | tmo ? LSU_IDLE : LSU_REQ);
    always_comb begin
        dm_req = ~idle;
        lsu_stall = reset & (accept | dm_req);
        dm_we = dm_req & we_q;
        dm_be = dm_req ? be : 4'b0000;
        dm_addr = {addr_q[31:2], 2'b00};
        dm_wdata = wdata_rep;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            wdata_q <= '0;
            size_q <= '0;
            sgn_q <= 1'b0;
            we_q <= 1'b0;
            rw_q <= 1'b0;
            rd_q <= '0;
            cnt <= '0;
            wb_valid <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_rd <= '0;
            wb_data <= '0;
            bus_err <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= in_addr;
                wdata_q <= in_wdata;
                size_q <= in_size;
                sgn_q <= in_lsigned;
                we_q <= in_memwrite;
                rw_q <= in_regwrite;
                rd_q <= in_rd;
            end
            cnt <= ~idle & ~done & ~tmo ? cnt + 1'b1 : '0;
            wb_valid <= idle ? in_valid & ~accept : done | tmo;
            wb_regwrite <= idle ? in_valid & ~mem_op & in_regwrite : done & ~we_q & rw_q;
            wb_rd <= idle ? in_rd : rd_q;
            wb_data <= idle ? in_addr : (done & ~we_q ? ldata : '0);
            bus_err <= idle ? mis : tmo;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven directed checks for mem_lsu plus timeout/reset/misalign sequences
module tb_mem_lsu;
    logic        clk = 1'b0, reset = 1'b0;
    logic        in_valid = 1'b0, in_memread = 1'b0, in_memwrite = 1'b0, in_lsigned = 1'b0, in_regwrite = 1'b0;
    logic [1:0]  in_size = '0;
    logic [31:0] in_addr = '0, in_wdata = '0, dm_rdata = '0;
    logic [4:0]  in_rd = '0;
    logic        dm_ready = 1'b0;
    logic        dm_req, dm_we, lsu_stall, wb_valid, wb_regwrite, bus_err;
    logic [31:0] dm_addr, dm_wdata, wb_data;
    logic [3:0]  dm_be;
    logic [4:0]  wb_rd;
    int passed = 0, total = 0;

    mem_lsu #(.WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_memread(in_memread),
        .in_memwrite(in_memwrite), .in_size(in_size), .in_lsigned(in_lsigned),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .lsu_stall(lsu_stall), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_data(wb_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr, wdata, rdata;
        int          rdy;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_data;
        logic        e_rw;
        int          e_stall;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(int kind, logic [1:0] size, logic sgn, logic [31:0] addr, wdata, rdata,
                                int rdy, logic [4:0] rd, logic rw, logic [31:0] e_addr, logic [3:0] e_be,
                                logic [31:0] e_wdata, e_data, logic e_rw, int e_stall);
        vec_t v;
        v.kind = kind; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.rdy = rdy; v.rd = rd; v.rw = rw; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_data = e_data; v.e_rw = e_rw; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input int kind, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic rw);
        in_valid = 1'b1; in_memread = kind == 1; in_memwrite = kind == 2; in_size = size;
        in_lsigned = sgn; in_addr = addr; in_wdata = wdata; in_rd = rd; in_regwrite = rw;
    endtask

    task automatic run(input int idx, input vec_t v);
        int stalls;
        string t;
        t = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(v.kind, v.size, v.sgn, v.addr, v.wdata, v.rd, v.rw);
        #1;
        stalls = int'(lsu_stall);
        chk({t, " idle_req"}, 32'(dm_req), 32'd0);
        @(posedge clk);
        for (int k = 1; k <= v.rdy; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            dm_ready = k == v.rdy;
            dm_rdata = v.rdata;
            #1;
            stalls += int'(lsu_stall);
            if (k == v.rdy) begin
                chk({t, " dm_req"}, 32'(dm_req), 32'd1);
                chk({t, " dm_we"}, 32'(dm_we), 32'(v.kind == 2));
                chk({t, " dm_addr"}, dm_addr, v.e_addr);
                chk({t, " dm_be"}, 32'(dm_be), 32'(v.e_be));
                chk({t, " dm_wdata"}, dm_wdata, v.e_wdata);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        dm_ready = 1'b0;
        #1;
        chk({t, " stall_cycles"}, 32'(stalls), 32'(v.e_stall));
        chk({t, " stall_after"}, 32'(lsu_stall), 32'd0);
        chk({t, " wb_valid"}, 32'(wb_valid), 32'd1);
        chk({t, " wb_regwrite"}, 32'(wb_regwrite), 32'(v.e_rw));
        chk({t, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
        chk({t, " bus_err"}, 32'(bus_err), 32'd0);
        if (v.kind != 2) chk({t, " wb_data"}, wb_data, v.e_data);
        @(negedge clk);
        #1;
        chk({t, " wb_valid_drop"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        int reqs;
        tbl[0]  = mk(2, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 2, 5'd1, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0, 3);
        tbl[1]  = mk(1, 2'b00, 1, 32'h103, 32'h0, 32'h80FF0000, 1, 5'd2, 1, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80, 1, 2);
        tbl[2]  = mk(1, 2'b01, 0, 32'h102, 32'h0, 32'h80011234, 1, 5'd4, 1, 32'h100, 4'hC, 32'h0, 32'h00008001, 1, 2);
        tbl[3]  = mk(0, 2'b00, 0, 32'h55, 32'h0, 32'h0, 0, 5'd3, 1, 32'h0, 4'h0, 32'h0, 32'h55, 1, 0);
        tbl[4]  = mk(2, 2'b00, 0, 32'h201, 32'h123456A5, 32'h0, 1, 5'd6, 1, 32'h200, 4'h2, 32'hA5A5A5A5, 32'h0, 0, 2);
        tbl[5]  = mk(2, 2'b01, 0, 32'h20, 32'hCAFEBEEF, 32'h0, 3, 5'd8, 0, 32'h20, 4'h3, 32'hBEEFBEEF, 32'h0, 0, 4);
        tbl[6]  = mk(1, 2'b01, 1, 32'h0, 32'h0, 32'h1234F00D, 1, 5'd9, 1, 32'h0, 4'h3, 32'h0, 32'hFFFFF00D, 1, 2);
        tbl[7]  = mk(1, 2'b00, 0, 32'h1, 32'h0, 32'h00009A00, 2, 5'd10, 1, 32'h0, 4'h2, 32'h0, 32'h0000009A, 1, 3);
        tbl[8]  = mk(1, 2'b10, 1, 32'h8, 32'h0, 32'h89ABCDEF, 4, 5'd11, 1, 32'h8, 4'hF, 32'h0, 32'h89ABCDEF, 1, 5);
        tbl[9]  = mk(1, 2'b00, 1, 32'hC, 32'h0, 32'h0000007F, 1, 5'd12, 0, 32'hC, 4'h1, 32'h0, 32'h0000007F, 0, 2);
        tbl[10] = mk(1, 2'b11, 0, 32'h10, 32'h0, 32'h11223344, 1, 5'd13, 1, 32'h10, 4'hF, 32'h0, 32'h11223344, 1, 2);
        tbl[11] = mk(1, 2'b10, 0, 32'h44, 32'h0, 32'hCAFEF00D, 16, 5'd14, 1, 32'h44, 4'hF, 32'h0, 32'hCAFEF00D, 1, 17);
        tbl[12] = mk(0, 2'b00, 0, 32'hFFFF0000, 32'h0, 32'h0, 0, 5'd31, 0, 32'h0, 4'h0, 32'h0, 32'hFFFF0000, 0, 0);

        #1;
        chk("rst dm_req", 32'(dm_req), 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst stall", 32'(lsu_stall), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) run(i, tbl[i]);

        // timeout: no dm_ready, expect 16 request cycles then bus_err
        @(negedge clk);
        drive(1, 2'b10, 0, 32'h40, 32'h0, 5'd7, 1);
        @(posedge clk);
        reqs = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            reqs += int'(dm_req);
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        chk("tmo req_cycles", 32'(reqs), 32'd16);
        chk("tmo dm_req", 32'(dm_req), 32'd0);
        chk("tmo bus_err", 32'(bus_err), 32'd1);
        chk("tmo wb_valid", 32'(wb_valid), 32'd1);
        chk("tmo wb_regwrite", 32'(wb_regwrite), 32'd0);
        @(negedge clk);
        #1;
        chk("tmo bus_err_pulse", 32'(bus_err), 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        drive(1, 2'b10, 0, 32'h101, 32'h0, 5'd15, 1);
        #1;
        chk("mis stall", 32'(lsu_stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mis dm_req", 32'(dm_req), 32'd0);
        chk("mis bus_err", 32'(bus_err), 32'd1);
        chk("mis wb_valid", 32'(wb_valid), 32'd1);
        chk("mis wb_regwrite", 32'(wb_regwrite), 32'd0);
`else
        run(13, mk(1, 2'b10, 0, 32'h101, 32'h0, 32'hA5A50001, 1, 5'd15, 1, 32'h100, 4'hF, 32'h0, 32'hA5A50001, 1, 2));
`endif

        // reset in the middle of a request
        @(negedge clk);
        drive(2, 2'b10, 0, 32'h300, 32'h77777777, 5'd16, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rreq dm_req", 32'(dm_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rreq dm_req_drop", 32'(dm_req), 32'd0);
        chk("rreq stall", 32'(lsu_stall), 32'd0);
        chk("rreq dm_we", 32'(dm_we), 32'd0);
        chk("rreq dm_be", 32'(dm_be), 32'd0);
        chk("rreq dm_addr", dm_addr, 32'd0);
        chk("rreq dm_wdata", dm_wdata, 32'd0);
        chk("rreq wb_valid", 32'(wb_valid), 32'd0);
        chk("rreq wb_rd", 32'(wb_rd), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rreq idle_after", 32'(dm_req), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
